// File: rtl/qs_stream_feeder_if.sv
// Host-write and sorter-stream signals for qs_stream_feeder.
// The master side is the host/sorter environment; the slave side is the feeder.
interface qs_stream_feeder_if #(
  parameter int pDATA_WIDTH = 32,
  parameter int pDEPTH      = 16
) ();
  localparam int CW = $clog2(pDEPTH) + 1;

  logic                   wr_valid;
  logic [pDATA_WIDTH-1:0] wr_data;
  logic                   wr_ready;
  logic                   clear;
  logic                   ss_tvalid;
  logic [pDATA_WIDTH-1:0] ss_tdata;
  logic                   ss_tlast;
  logic                   ss_tready;
  logic [CW-1:0]          fifo_count;
  logic                   frame_done;

  modport master (
    output wr_valid, wr_data, clear, ss_tready,
    input  wr_ready, ss_tvalid, ss_tdata, ss_tlast, fifo_count, frame_done
  );

  modport slave (
    input  wr_valid, wr_data, clear, ss_tready,
    output wr_ready, ss_tvalid, ss_tdata, ss_tlast, fifo_count, frame_done
  );
endinterface

// File: rtl/qs_stream_feeder.sv
// Show-ahead FIFO that feeds a sorter in fixed-length frames with tlast/frame_done.
// Optional macro QS_FEEDER_FRAME_HOLD_EN: withhold a frame until it is fully buffered.
module qs_stream_feeder #(
  parameter int pDATA_WIDTH = 32,
  parameter int pDEPTH      = 16,
  parameter int pFRAME_LEN  = 10
) (
  input  logic               axis_clk,
  input  logic               axis_rst,
  qs_stream_feeder_if.slave  bus
);
  localparam int PW = $clog2(pDEPTH);
  localparam int CW = PW + 1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(pDEPTH);
  localparam logic [5:0]    LAST_IDX = 6'(pFRAME_LEN - 1);

  logic [pDATA_WIDTH-1:0] mem_q [pDEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [5:0]             word_idx_q, word_idx_d;
  logic [0:0]             state_q, state_d;
  logic                   frame_done_q, frame_done_d;

  logic empty, wr_ready, tvalid, tlast, push, pop;

  assign empty    = (count_q == '0);
  assign wr_ready = (count_q < DEPTH_C);

`ifdef QS_FEEDER_FRAME_HOLD_EN
  // At a frame boundary nothing is offered until a whole frame is buffered.
  assign tvalid = (state_q == IDLE) ? (32'(count_q) >= 32'(pFRAME_LEN)) : !empty;
`else
  assign tvalid = !empty;
`endif

  assign tlast = tvalid && (word_idx_q == LAST_IDX);
  assign push  = bus.wr_valid && wr_ready && !bus.clear;
  assign pop   = tvalid && bus.ss_tready && !bus.clear;

  assign bus.wr_ready   = wr_ready;
  assign bus.ss_tvalid  = tvalid;
  assign bus.ss_tlast   = tlast;
  // Storage is never reset, so the head is masked until something is written.
  assign bus.ss_tdata   = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.fifo_count = count_q;
  assign bus.frame_done = frame_done_q;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    word_idx_d   = word_idx_q;
    state_d      = state_q;
    frame_done_d = 1'b0;
    if (bus.clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      word_idx_d = '0;
      state_d    = IDLE;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (pop) begin
        frame_done_d = tlast;
        if (tlast) begin
          word_idx_d = '0;
          state_d    = IDLE;
        end else begin
          word_idx_d = word_idx_q + 6'd1;
          state_d    = STREAM;
        end
      end
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      word_idx_q   <= '0;
      state_q      <= IDLE;
      frame_done_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      word_idx_q   <= word_idx_d;
      state_q      <= state_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end
endmodule
